// File: rtl/windowed_wdt_if.sv
// Windowed watchdog bus: enable/kick/threshold inputs and the registered status outputs.
// master drives the controls, slave is the watchdog itself.
interface windowed_wdt_if #(
   parameter int CNT_W = 16
);
   logic             wdt_en;
   logic             kick;
   logic [CNT_W-1:0] timeout;
   logic [CNT_W-1:0] win_start;
   logic [CNT_W-1:0] warn_lvl;
   logic [CNT_W-1:0] cnt_o;
   logic             warn_o;
   logic             rst_o;
   logic [1:0]       cause_o;

   modport master (
      output wdt_en, kick, timeout, win_start, warn_lvl,
      input  cnt_o, warn_o, rst_o, cause_o
   );

   modport slave (
      input  wdt_en, kick, timeout, win_start, warn_lvl,
      output cnt_o, warn_o, rst_o, cause_o
   );
endinterface

// File: rtl/windowed_wdt.sv
// Windowed watchdog: kicks must land in [win_start, timeout]; early kicks and expiry fire rst_o.
// Optional build macro WDT_LOCK_EN: once started, wdt_en=0 is ignored until rst.
//
// state  | meaning
// S_IDLE | disabled, thresholds tracked from inputs every cycle
// S_RUN  | counting, thresholds frozen, kicks checked against window
// S_FIRE | rst_o asserted for RST_PULSE cycles, kicks ignored
module windowed_wdt #(
   parameter int CNT_W     = 16,
   parameter int RST_PULSE = 4
) (
   input logic           clk,
   input logic           rst,
   windowed_wdt_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIRE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ZERO       = '0;
   localparam logic [7:0]       PULSE_LAST = 8'(RST_PULSE - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] t_r;
   logic [CNT_W-1:0] w_r;
   logic [CNT_W-1:0] a_r;
   logic [7:0]       pcnt;
   logic             warn;
   logic             rst_pulse;
   logic [1:0]       cause;
   logic [CNT_W-1:0] cnt_inc;
   logic             en_eff;

   assign cnt_inc = cnt + ONE;

`ifdef WDT_LOCK_EN
   logic lock;
   assign en_eff = bus.wdt_en | lock;
`else
   assign en_eff = bus.wdt_en;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         t_r       <= '0;
         w_r       <= '0;
         a_r       <= '0;
         pcnt      <= '0;
         warn      <= 1'b0;
         rst_pulse <= 1'b0;
         cause     <= 2'b00;
`ifdef WDT_LOCK_EN
         lock      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               t_r       <= bus.timeout;
               w_r       <= bus.win_start;
               a_r       <= bus.warn_lvl;
               cnt       <= '0;
               rst_pulse <= 1'b0;
               warn      <= 1'b0;
               if (bus.wdt_en) begin
                  state <= S_RUN;
                  // first RUN cycle shows cnt 0, so warning only if the level is 0
                  warn  <= (bus.warn_lvl == ZERO);
`ifdef WDT_LOCK_EN
                  lock  <= 1'b1;
`endif
               end
            end

            S_RUN: begin
               if (!en_eff) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  warn  <= 1'b0;
               end else if (bus.kick && (cnt >= w_r)) begin
                  cnt  <= '0;
                  warn <= (a_r == ZERO);
               end else if (bus.kick || (cnt == t_r)) begin
                  state     <= S_FIRE;
                  cnt       <= '0;
                  warn      <= 1'b0;
                  rst_pulse <= 1'b1;
                  pcnt      <= PULSE_LAST;
                  cause     <= bus.kick ? 2'b10 : 2'b01;
               end else begin
                  cnt  <= cnt_inc;
                  warn <= (cnt_inc >= a_r);
               end
            end

            S_FIRE: begin
               if (pcnt == 8'd0) begin
                  rst_pulse <= 1'b0;
                  t_r       <= bus.timeout;
                  w_r       <= bus.win_start;
                  a_r       <= bus.warn_lvl;
                  if (en_eff) begin
                     state <= S_RUN;
                     warn  <= (bus.warn_lvl == ZERO);
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  pcnt <= pcnt - 8'd1;
               end
            end

            default: begin
               state     <= S_IDLE;
               cnt       <= '0;
               warn      <= 1'b0;
               rst_pulse <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cnt_o   = cnt;
   assign bus.warn_o  = warn;
   assign bus.rst_o   = rst_pulse;
   assign bus.cause_o = cause;

endmodule

// File: tb/tb_windowed_wdt.sv
// Bench for windowed_wdt: fixed vector table, directed corner sequences, then random traffic
// checked every cycle against a behavioural model of the watchdog rules.
module tb_windowed_wdt;

   localparam int CNT_W     = 8;
   localparam int RST_PULSE = 4;

   logic clk;
   logic rst;

   windowed_wdt_if #(.CNT_W(CNT_W)) bus ();

   windowed_wdt #(
      .CNT_W    (CNT_W),
      .RST_PULSE(RST_PULSE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // model state
   bit m_running;
   bit m_lock;
   int m_cnt;
   int m_fire_left;
   int m_cause;
   int m_T, m_W, m_A;

   typedef struct {
      logic rst;
      logic en;
      logic kick;
      int   cnt;
      logic warn;
      logic rsto;
      int   cause;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic r, logic e, logic k, int c, logic w, logic ro, int ca);
      vec_t v;
      v.rst = r; v.en = e; v.kick = k; v.cnt = c; v.warn = w; v.rsto = ro; v.cause = ca;
      vecs.push_back(v);
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic void sample_thresholds();
      m_T = int'(bus.timeout);
      m_W = int'(bus.win_start);
      m_A = int'(bus.warn_lvl);
   endfunction

   function automatic void start_fire(int c);
      m_fire_left = RST_PULSE;
      m_cause     = c;
      m_running   = 1'b0;
      m_cnt       = 0;
   endfunction

   // Applies the watchdog rules to the inputs present at this clock edge.
   function automatic void model_step();
      bit en;
      en = bus.wdt_en;
      if (rst) begin
         m_running = 0; m_lock = 0; m_cnt = 0; m_fire_left = 0; m_cause = 0;
      end else if (m_fire_left > 0) begin
         m_fire_left--;
         if (m_fire_left == 0) begin
            sample_thresholds();
            m_cnt     = 0;
            m_running = en || m_lock;
         end
      end else if (!m_running) begin
         sample_thresholds();
         m_cnt = 0;
         if (en) begin
            m_running = 1;
`ifdef WDT_LOCK_EN
            m_lock = 1;
`endif
         end
      end else if (!(en || m_lock)) begin
         m_running = 0;
         m_cnt     = 0;
      end else if (bus.kick) begin
         if (m_cnt >= m_W) m_cnt = 0;
         else start_fire(2);
      end else if (m_cnt == m_T) begin
         start_fire(1);
      end else begin
         m_cnt++;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      chk("model_cnt_o",   int'(bus.cnt_o),   m_cnt);
      chk("model_warn_o",  int'(bus.warn_o),  int'(m_running && (m_cnt >= m_A)));
      chk("model_rst_o",   int'(bus.rst_o),   int'(m_fire_left > 0));
      chk("model_cause_o", int'(bus.cause_o), m_cause);
   endtask

   task automatic set_cfg(int t, int w, int a);
      bus.timeout   = 8'(t);
      bus.win_start = 8'(w);
      bus.warn_lvl  = 8'(a);
   endtask

   task automatic do_reset();
      rst = 1'b1; bus.wdt_en = 1'b0; bus.kick = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int seen;
      int warn_seen;
      rst = 1'b1;
      bus.wdt_en = 1'b0;
      bus.kick   = 1'b0;
      set_cfg(10, 4, 8);

      // ---------------- vector table ----------------
      add(1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) add(0, 1, 0, i, (i >= 8), 0, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 1, 1);
      add(0, 1, 0, 0, 0, 0, 1);
      add(0, 1, 0, 1, 0, 0, 1);
      add(0, 1, 0, 2, 0, 0, 1);
      add(0, 1, 1, 0, 0, 1, 2);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 1, 2);
      add(0, 1, 0, 0, 0, 0, 2);
      for (int i = 1; i <= 6; i++) add(0, 1, 0, i, 0, 0, 2);
      add(0, 1, 1, 0, 0, 0, 2);
      add(0, 1, 0, 1, 0, 0, 2);
      add(1, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         rst        = vecs[i].rst;
         bus.wdt_en = vecs[i].en;
         bus.kick   = vecs[i].kick;
         tick();
         chk($sformatf("tbl%0d_cnt", i),   int'(bus.cnt_o),   vecs[i].cnt);
         chk($sformatf("tbl%0d_warn", i),  int'(bus.warn_o),  int'(vecs[i].warn));
         chk($sformatf("tbl%0d_rst_o", i), int'(bus.rst_o),   int'(vecs[i].rsto));
         chk($sformatf("tbl%0d_cause", i), int'(bus.cause_o), vecs[i].cause);
      end
      rst = 1'b0;

      // kick exactly at cnt == T wins over expiry
      do_reset();
      bus.wdt_en = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      chk("kick_at_T_pre_cnt", int'(bus.cnt_o), 10);
      bus.kick = 1'b1;
      tick();
      bus.kick = 1'b0;
      chk("kick_at_T_cnt", int'(bus.cnt_o), 0);
      chk("kick_at_T_rst_o", int'(bus.rst_o), 0);
      chk("kick_at_T_cause", int'(bus.cause_o), 0);

      // enable dropped at cnt 5
      do_reset();
      bus.wdt_en = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      chk("en_drop_pre_cnt", int'(bus.cnt_o), 5);
      bus.wdt_en = 1'b0;
      tick();
`ifdef WDT_LOCK_EN
      chk("en_drop_cnt", int'(bus.cnt_o), 6);
`else
      chk("en_drop_cnt", int'(bus.cnt_o), 0);
`endif
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.rst_o) seen = 1;
      end
`ifdef WDT_LOCK_EN
      chk("en_drop_fire", seen, 1);
`else
      chk("en_drop_fire", seen, 0);
`endif

      // rst in the second FIRE cycle
      do_reset();
      bus.wdt_en = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      tick();
      chk("fire1_rst_o", int'(bus.rst_o), 1);
      chk("fire1_cause", int'(bus.cause_o), 1);
      tick();
      chk("fire2_rst_o", int'(bus.rst_o), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_fire_rst_o", int'(bus.rst_o), 0);
      chk("rst_mid_fire_cause", int'(bus.cause_o), 0);
      chk("rst_mid_fire_cnt", int'(bus.cnt_o), 0);
      bus.wdt_en = 1'b0;
      tick();
      tick();
      chk("rst_mid_fire_idle_cnt", int'(bus.cnt_o), 0);

      // kicking every 7 cycles keeps the watchdog quiet
      do_reset();
      bus.wdt_en = 1'b1;
      tick();
      seen = 0;
      warn_seen = 0;
      for (int i = 0; i < 30; i++) begin
         bus.kick = (m_cnt == 6);
         tick();
         if (bus.rst_o) seen = 1;
         if (bus.warn_o) warn_seen = 1;
      end
      bus.kick = 1'b0;
      chk("periodic_kick_rst_o", seen, 0);
      chk("periodic_kick_warn", warn_seen, 0);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 199) == 0);
         bus.wdt_en = ($urandom_range(0, 19) != 0);
         bus.kick   = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 3) == 0)
            set_cfg($urandom_range(0, 15), $urandom_range(0, 18), $urandom_range(0, 16));
         tick();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/windowed_wdt.md
WINDOWED_WDT -- requirements
Module: windowed_wdt

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the counter and of the threshold inputs.
REQ-002 SHALL have parameter RST_PULSE, default 4: rst_o pulse length in cycles, 1 to 255.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk and rst; no other clock or async input.
REQ-004 Ports, as name, direction, width, meaning:
- clk in 1: clock, rising edge.
- rst in 1: synchronous active-high reset.
- wdt_en in 1: watchdog enable.
- kick in 1: service pulse, sampled each cycle.
- timeout in CNT_W: expiry count T.
- win_start in CNT_W: earliest legal kick count W.
- warn_lvl in CNT_W: pre-timeout warning count A.
- cnt_o out CNT_W: current count.
- warn_o out 1: pre-timeout warning.
- rst_o out 1: watchdog reset pulse.
- cause_o out 2: last fire cause (00 none, 01 timeout, 10 early kick).

Function
REQ-005 SHALL implement the FSM IDLE, RUN and FIRE.
REQ-006 IDLE: cnt_o=0, warn_o=0, rst_o=0; T, W and A sampled into internal registers every cycle; wdt_en=1 -> RUN next cycle with cnt=0.
REQ-007 RUN: T, W and A frozen; cnt increments by 1 per cycle with no kick.
REQ-008 RUN, kick=1 and cnt>=W (legal kick): cnt=0 next cycle, warn_o cleared, no fire.
REQ-009 RUN, kick=1 and cnt<W (early kick): -> FIRE next cycle, cause_o=10.
REQ-010 RUN, cnt==T and no legal kick: -> FIRE next cycle, cause_o=01.
- cnt never exceeds T.
- T=0 fires after one RUN cycle.
REQ-011 Simultaneous legal kick and cnt==T: the kick wins and no fire occurs.
REQ-012 W>T: every kick is early. This is legal and SHALL NOT be flagged otherwise.
REQ-013 warn_o=1 exactly in RUN cycles where cnt_o>=A, aligned with cnt_o.
REQ-014 FIRE: rst_o=1 for exactly RUN_PULSE... specifically RST_PULSE consecutive cycles; cnt_o=0, warn_o=0; kick ignored.
REQ-015 FIRE exit: -> RUN with cnt=0 if wdt_en=1, else -> IDLE. T, W and A are re-sampled on that transition.
REQ-016 wdt_en=0 during RUN: -> IDLE next cycle, cnt cleared. Takes priority over kick and expiry in the same cycle.
REQ-017 wdt_en=0 during FIRE: the pulse SHALL still complete.
REQ-018 cause_o holds until the next fire or rst; leaving IDLE does not clear it.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 rst=1 at a clock edge: next state IDLE, cnt_o=0, warn_o=0, rst_o=0, cause_o=00, lock cleared.
REQ-021 rst SHALL take priority over every event, including mid-FIRE: rst_o drops the next cycle.

Configuration
REQ-022 SHALL support macro WDT_LOCK_EN.
- Defined: the first IDLE->RUN transition sets a lock. While locked, wdt_en=0 is ignored in RUN and after FIRE (FIRE always returns to RUN). Only rst clears the lock.
- Undefined: no lock logic; REQ-016 and REQ-017 apply unchanged.

Verification
Settings for all scenarios: CNT_W=8, RST_PULSE=4, T=10, W=4, A=8.
REQ-023 Enable, never kick -> cnt_o 0..10; warn_o high at cnt_o 8..10; rst_o high 4 cycles starting the cycle after cnt_o=10; cause_o=01; then RUN again from 0.
REQ-024 Kick at cnt_o=6 -> cnt_o=0 next cycle; warn_o never asserts; no rst_o over 30 cycles of kicking every 7 cycles.
REQ-025 Kick at cnt_o=2 -> rst_o high the next cycle for 4 cycles; cause_o=10.
REQ-026 Kick at cnt_o=10 -> cnt_o=0 next cycle; rst_o stays 0.
REQ-027 Deassert wdt_en at cnt_o=5:
- Macro undefined -> IDLE, cnt_o=0, no fire.
- Macro defined -> counting continues and fires after cnt_o=10.
REQ-028 Assert rst in the 2nd FIRE cycle -> rst_o=0, cause_o=00, cnt_o=0 the next cycle; state IDLE.
